mem_access_unit: RTL and testbench

//  MEM stage directly downstream of the EX logic/ALU units. Takes the EX result as the load/store

---
 rtl/mem_access_unit_pkg.sv | 39 +++
 rtl/mem_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM stage (mem_access_unit and mem_align).
package mem_access_unit_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } mau_state_t;

  // Byte lane actually used: halves ignore addr[0], words ignore both low bits.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] lane;
    case (size)
      MEM_SIZE_BYTE: lane = off;
      MEM_SIZE_HALF: lane = {off[1], 1'b0};
      default:       lane = 2'b00;
    endcase
    return lane;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      MEM_SIZE_BYTE: bad = 1'b0;
      MEM_SIZE_HALF: bad = off[0];
      default:       bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational store byte-enable/lane replication and load extract/sign-or-zero extend.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_be,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [1:0]        ld_size,
  input  logic [1:0]        ld_off,
  input  logic              ld_uns,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] ld_data
);

  logic [1:0]        st_lane;
  logic [1:0]        ld_lane;
  logic [DATA_W-1:0] ld_shift;

  always_comb begin
    st_lane = lane_offset(st_size, st_off);
    case (st_size)
      MEM_SIZE_BYTE: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_SIZE_HALF: begin
        st_be    = 4'b0011 << st_lane;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_lane  = lane_offset(ld_size, ld_off);
    ld_shift = ld_raw >> {ld_lane, 3'b000};
    case (ld_size)
      MEM_SIZE_BYTE: ld_data = {{24{~ld_uns & ld_shift[7]}}, ld_shift[7:0]};
      MEM_SIZE_HALF: ld_data = {{16{~ld_uns & ld_shift[15]}}, ld_shift[15:0]};
      default:       ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: req/gnt/rvalid data-RAM access, load alignment, pipeline stall, registered MEM/WB outputs.
// Optional MEM_MISALIGN_TRAP_EN adds exc_misalign/exc_badaddr and traps misaligned half/word ops.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_mem_rd,
  input  logic                  ex_mem_wr,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_uns,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [REG_ADDR_W-1:0] ex_reg_addr,
  input  logic                  ex_reg_en,
  output logic                  stall_req,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_addr,
  output logic [3:0]            ram_be,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic                  ram_gnt,
  input  logic                  ram_rvalid,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_reg_addr,
  output logic                  wb_reg_en,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  exc_misalign,
  output logic [DATA_W-1:0]     exc_badaddr,
`endif
  output logic                  bus_err
);

  localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);

  mau_state_t            state;
  logic [CNT_W-1:0]      tmo_cnt;
  logic [1:0]            op_size;
  logic [1:0]            op_off;
  logic                  op_uns;
  logic                  op_reg_en;
  logic [REG_ADDR_W-1:0] op_reg_addr;

  logic                  is_mem;
  logic                  trap;
  logic                  accept;
  logic                  tmo_hit;
  logic                  resp_done;
  logic [3:0]            be_n;
  logic [DATA_W-1:0]     wdata_n;
  logic [DATA_W-1:0]     ld_data;

  assign is_mem = ex_mem_rd | ex_mem_wr;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem & misaligned(ex_mem_size, ex_result[1:0]);
`else
  assign trap = 1'b0;
`endif
  assign accept    = (state == ST_IDLE) & ex_valid & is_mem & ~flush & ~trap;
  assign stall_req = (state != ST_IDLE) | accept;
  assign tmo_hit   = ~ram_rvalid & (tmo_cnt == CNT_W'(RESP_TIMEOUT - 1));
  assign resp_done = ram_rvalid | tmo_hit;

  mem_align u_align (
    .st_size  (ex_mem_size),
    .st_off   (ex_result[1:0]),
    .st_data  (ex_wdata),
    .st_be    (be_n),
    .st_wdata (wdata_n),
    .ld_size  (op_size),
    .ld_off   (op_off),
    .ld_uns   (op_uns),
    .ld_raw   (ram_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      tmo_cnt      <= '0;
      op_size      <= '0;
      op_off       <= '0;
      op_uns       <= 1'b0;
      op_reg_en    <= 1'b0;
      op_reg_addr  <= '0;
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_be       <= '0;
      ram_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_reg_addr  <= '0;
      wb_reg_en    <= 1'b0;
      bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      exc_misalign <= 1'b0;
      exc_badaddr  <= '0;
`endif
    end else begin
      wb_valid     <= 1'b0;
      bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      exc_misalign <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (!flush && ex_valid) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (trap) begin
              wb_valid     <= 1'b1;
              wb_data      <= '0;
              wb_reg_addr  <= ex_reg_addr;
              wb_reg_en    <= 1'b0;
              exc_misalign <= 1'b1;
              exc_badaddr  <= ex_result;
            end else
`endif
            if (is_mem) begin
              state       <= ST_REQ;
              ram_req     <= 1'b1;
              ram_we      <= ex_mem_wr;
              ram_addr    <= {ex_result[DATA_W-1:2], 2'b00};
              ram_be      <= be_n;
              ram_wdata   <= wdata_n;
              op_size     <= ex_mem_size;
              op_off      <= ex_result[1:0];
              op_uns      <= ex_mem_uns;
              op_reg_en   <= ex_reg_en;
              op_reg_addr <= ex_reg_addr;
            end else begin
              wb_valid    <= 1'b1;
              wb_data     <= ex_result;
              wb_reg_addr <= ex_reg_addr;
              wb_reg_en   <= ex_reg_en;
            end
          end
        end
        ST_REQ: begin
          // A granted request will be answered, so a same-cycle flush must still drain it.
          if (ram_gnt) begin
            ram_req <= 1'b0;
            tmo_cnt <= '0;
            state   <= flush ? ST_DRAIN : ST_WAIT;
          end else if (flush) begin
            ram_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (resp_done) begin
            state <= ST_IDLE;
            if (!flush) begin
              wb_valid    <= 1'b1;
              wb_reg_addr <= op_reg_addr;
              if (tmo_hit) begin
                bus_err   <= 1'b1;
                wb_data   <= '0;
                wb_reg_en <= 1'b0;
              end else begin
                wb_data   <= ram_we ? '0 : ld_data;
                wb_reg_en <= ~ram_we & op_reg_en;
              end
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (flush) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (resp_done) state <= ST_IDLE;
          else           tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default build; MEM_MISALIGN_TRAP_EN adds trap checks).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, ex_mem_rd, ex_mem_wr, ex_mem_uns, ex_reg_en;
  logic [1:0]  ex_mem_size;
  logic [31:0] ex_result, ex_wdata;
  logic [4:0]  ex_reg_addr;
  logic        stall_req, ram_req, ram_we, ram_gnt, ram_rvalid;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_be;
  logic        wb_valid, wb_reg_en, bus_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg_addr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        exc_misalign;
  logic [31:0] exc_badaddr;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Observations returned by mem_txn.
  logic [31:0] t_addr, t_wdata, t_wd;
  logic [3:0]  t_be;
  logic [4:0]  t_wra;
  logic        t_we, t_req_ok, t_wv, t_wen, t_err, t_sa;
  int          t_stalls;

  always #5 clk = ~clk;

  mem_access_unit #(.RESP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_mem_size(ex_mem_size), .ex_mem_uns(ex_mem_uns),
    .ex_result(ex_result), .ex_wdata(ex_wdata), .ex_reg_addr(ex_reg_addr), .ex_reg_en(ex_reg_en),
    .stall_req(stall_req), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_gnt(ram_gnt), .ram_rvalid(ram_rvalid),
    .ram_rdata(ram_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg_addr(wb_reg_addr),
    .wb_reg_en(wb_reg_en),
`ifdef MEM_MISALIGN_TRAP_EN
    .exc_misalign(exc_misalign), .exc_badaddr(exc_badaddr),
`endif
    .bus_err(bus_err)
  );

  // Runs one memory op through accept / REQ (gnt after gnt_delay) / WAIT (rvalid after rv_delay).
  task automatic mem_txn(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd_reg,
                         input int gnt_delay, input int rv_delay, input logic give_rv,
                         input logic [31:0] rdata);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_rd = ~wr; ex_mem_wr = wr; ex_mem_size = size; ex_mem_uns = uns;
    ex_result = addr; ex_wdata = wdata; ex_reg_addr = rd_reg; ex_reg_en = 1'b1;
    ram_gnt = 1'b0; ram_rvalid = 1'b0;
    t_stalls = 0; t_req_ok = 1'b1;
    @(negedge clk);
    if (stall_req) t_stalls++;
    if (ram_req !== 1'b0) t_req_ok = 1'b0;
    @(posedge clk); #1;
    t_addr = ram_addr; t_be = ram_be; t_wdata = ram_wdata; t_we = ram_we;
    for (int i = 0; i <= gnt_delay; i++) begin
      if (i == gnt_delay) ram_gnt = 1'b1;
      @(negedge clk);
      if (stall_req) t_stalls++;
      if (ram_req !== 1'b1 || ram_addr !== t_addr || ram_be !== t_be || ram_wdata !== t_wdata)
        t_req_ok = 1'b0;
      @(posedge clk); #1;
    end
    ram_gnt = 1'b0;
    if (ram_req !== 1'b0) t_req_ok = 1'b0;
    for (int i = 0; i < rv_delay; i++) begin
      @(negedge clk);
      if (stall_req) t_stalls++;
      @(posedge clk); #1;
    end
    if (give_rv) begin
      ram_rvalid = 1'b1; ram_rdata = rdata;
      @(negedge clk);
      if (stall_req) t_stalls++;
      @(posedge clk); #1;
      ram_rvalid = 1'b0; ram_rdata = 32'hA5A5_A5A5;
    end
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    @(negedge clk);
    t_wv = wb_valid; t_wd = wb_data; t_wen = wb_reg_en; t_wra = wb_reg_addr;
    t_err = bus_err; t_sa = stall_req;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    ex_mem_size = 2'b00; ex_mem_uns = 1'b0; ex_result = '0; ex_wdata = '0;
    ex_reg_addr = '0; ex_reg_en = 1'b0; ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = 32'hA5A5_A5A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (ram_req !== 1'b0) begin miscompares++; $display("FAIL reset_ram_req: got %b want 0", ram_req); end
    vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    vectors++; if ({wb_data, ram_addr, ram_wdata} !== 96'h0) begin miscompares++; $display("FAIL reset_data: got %h %h %h want 0", wb_data, ram_addr, ram_wdata); end
    vectors++; if ({ram_be, wb_reg_en, bus_err, ram_we, wb_reg_addr} !== 12'h0) begin miscompares++; $display("FAIL reset_ctrl: got %b want 0", {ram_be, wb_reg_en, bus_err, ram_we, wb_reg_addr}); end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_passthrough();
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_result = 32'h0000_55AA; ex_reg_addr = 5'd7; ex_reg_en = 1'b1;
    @(negedge clk);
    vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL pass_stall: got %b want 0", stall_req); end
    @(posedge clk); #1;
    ex_result = 32'h0000_1234; ex_reg_addr = 5'd3; ex_reg_en = 1'b0;
    @(negedge clk);
    vectors++; if ({wb_valid, wb_reg_en, wb_reg_addr, wb_data} !== {1'b1, 1'b1, 5'd7, 32'h0000_55AA}) begin miscompares++; $display("FAIL pass_op1: got %b %b %0d %h want 1 1 7 000055aa", wb_valid, wb_reg_en, wb_reg_addr, wb_data); end
    @(posedge clk); #1; ex_valid = 1'b0;
    @(negedge clk);
    vectors++; if ({wb_valid, wb_reg_en, wb_reg_addr, wb_data} !== {1'b1, 1'b0, 5'd3, 32'h0000_1234}) begin miscompares++; $display("FAIL pass_op2: got %b %b %0d %h want 1 0 3 00001234", wb_valid, wb_reg_en, wb_reg_addr, wb_data); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL pass_bubble: got %b want 0", wb_valid); end
  endtask

  task automatic test_load_word();
    mem_txn(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd5, 0, 0, 1'b1, 32'hDEAD_BEEF);
    vectors++; if ({t_addr, t_be, t_we} !== {32'h0000_0100, 4'b1111, 1'b0}) begin miscompares++; $display("FAIL lw_req: got %h %b %b want 00000100 1111 0", t_addr, t_be, t_we); end
    vectors++; if (t_req_ok !== 1'b1) begin miscompares++; $display("FAIL lw_req_shape: got %b want 1", t_req_ok); end
    vectors++; if (t_stalls != 3) begin miscompares++; $display("FAIL lw_stall_cycles: got %0d want 3", t_stalls); end
    vectors++; if ({t_wv, t_wen, t_wra, t_err, t_sa} !== {1'b1, 1'b1, 5'd5, 1'b0, 1'b0}) begin miscompares++; $display("FAIL lw_wb_ctrl: got %b want 1100101 00", {t_wv, t_wen, t_wra, t_err, t_sa}); end
    vectors++; if (t_wd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_wb_data: got %h want deadbeef", t_wd); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL lw_bubble: got %b want 0", wb_valid); end
  endtask

  task automatic test_load_subword();
    mem_txn(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd1, 0, 0, 1'b1, 32'h8011_2233);
    vectors++; if ({t_addr, t_be} !== {32'h0000_0100, 4'b1000}) begin miscompares++; $display("FAIL lb_req: got %h %b want 00000100 1000", t_addr, t_be); end
    vectors++; if (t_wd !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data: got %h want ffffff80", t_wd); end
    mem_txn(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 5'd1, 0, 0, 1'b1, 32'h8011_2233);
    vectors++; if (t_wd !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_data: got %h want 00000080", t_wd); end
    mem_txn(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 5'd2, 0, 0, 1'b1, 32'h8001_7FFF);
    vectors++; if (t_be !== 4'b1100) begin miscompares++; $display("FAIL lh_be: got %b want 1100", t_be); end
    vectors++; if (t_wd !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_data: got %h want ffff8001", t_wd); end
    mem_txn(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 5'd2, 0, 0, 1'b1, 32'h1234_F00D);
    vectors++; if ({t_be, t_wd} !== {4'b0011, 32'h0000_F00D}) begin miscompares++; $display("FAIL lhu: got %b %h want 0011 0000f00d", t_be, t_wd); end
  endtask

  task automatic test_store();
    mem_txn(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 5'd4, 0, 0, 1'b1, 32'hFFFF_FFFF);
    vectors++; if ({t_addr, t_be, t_we} !== {32'h0000_0200, 4'b1100, 1'b1}) begin miscompares++; $display("FAIL sh_req: got %h %b %b want 00000200 1100 1", t_addr, t_be, t_we); end
    vectors++; if (t_wdata !== 32'hABCD_ABCD) begin miscompares++; $display("FAIL sh_wdata: got %h want abcdabcd", t_wdata); end
    vectors++; if ({t_wv, t_wen, t_wd} !== {1'b1, 1'b0, 32'h0}) begin miscompares++; $display("FAIL sh_wb: got %b %b %h want 1 0 00000000", t_wv, t_wen, t_wd); end
    mem_txn(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_005A, 5'd4, 0, 0, 1'b1, 32'h0);
    vectors++; if ({t_be, t_wdata} !== {4'b0010, 32'h5A5A_5A5A}) begin miscompares++; $display("FAIL sb: got %b %h want 0010 5a5a5a5a", t_be, t_wdata); end
    mem_txn(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_BABE, 5'd4, 0, 0, 1'b1, 32'h0);
    vectors++; if ({t_be, t_wdata} !== {4'b1111, 32'hCAFE_BABE}) begin miscompares++; $display("FAIL sw: got %b %h want 1111 cafebabe", t_be, t_wdata); end
  endtask

  task automatic test_gnt_stall();
    mem_txn(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd6, 5, 2, 1'b1, 32'h0BAD_F00D);
    vectors++; if (t_req_ok !== 1'b1) begin miscompares++; $display("FAIL gnt_wait_req_stable: got %b want 1", t_req_ok); end
    vectors++; if (t_stalls != 10) begin miscompares++; $display("FAIL gnt_wait_stalls: got %0d want 10", t_stalls); end
    vectors++; if ({t_wv, t_wd} !== {1'b1, 32'h0BAD_F00D}) begin miscompares++; $display("FAIL gnt_wait_wb: got %b %h want 1 0badf00d", t_wv, t_wd); end
  endtask

  task automatic test_timeout();
    mem_txn(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd8, 0, 15, 1'b1, 32'h2468_ACE0);
    vectors++; if ({t_wv, t_err, t_wd, t_stalls} !== {1'b1, 1'b0, 32'h2468_ACE0, 32'd18}) begin miscompares++; $display("FAIL rvalid_last_cycle: got %b %b %h %0d want 1 0 2468ace0 18", t_wv, t_err, t_wd, t_stalls); end
    mem_txn(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd8, 0, 16, 1'b0, 32'h0);
    vectors++; if ({t_wv, t_err, t_wen, t_sa} !== 4'b1100) begin miscompares++; $display("FAIL timeout_ctrl: got %b want 1100", {t_wv, t_err, t_wen, t_sa}); end
    vectors++; if (t_wd !== 32'h0) begin miscompares++; $display("FAIL timeout_data: got %h want 0", t_wd); end
    vectors++; if (t_stalls != 18) begin miscompares++; $display("FAIL timeout_stalls: got %0d want 18", t_stalls); end
    @(posedge clk); #1; ram_rvalid = 1'b1; ram_rdata = 32'h1111_1111;
    @(negedge clk);
    vectors++; if ({bus_err, wb_valid} !== 2'b00) begin miscompares++; $display("FAIL timeout_pulse: got %b want 00", {bus_err, wb_valid}); end
    @(posedge clk); #1; ram_rvalid = 1'b0;
    @(negedge clk);
    vectors++; if ({wb_valid, stall_req, ram_req} !== 3'b000) begin miscompares++; $display("FAIL late_rvalid: got %b want 000", {wb_valid, stall_req, ram_req}); end
  endtask

  task automatic test_flush();
    // Flush one cycle after gnt: response is drained silently.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_size = 2'b10; ex_result = 32'h0000_0100; ex_reg_addr = 5'd9; ex_reg_en = 1'b1;
    @(posedge clk); #1; ram_gnt = 1'b1;
    @(posedge clk); #1; ram_gnt = 1'b0; flush = 1'b1; ex_valid = 1'b0; ex_mem_rd = 1'b0;
    @(negedge clk);
    vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("FAIL flush_wait_stall: got %b want 1", stall_req); end
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    vectors++; if ({stall_req, wb_valid} !== 2'b10) begin miscompares++; $display("FAIL drain_hold: got %b want 10", {stall_req, wb_valid}); end
    @(posedge clk); #1; ram_rvalid = 1'b1; ram_rdata = 32'h7777_7777;
    @(posedge clk); #1; ram_rvalid = 1'b0;
    @(negedge clk);
    vectors++; if ({wb_valid, bus_err, stall_req} !== 3'b000) begin miscompares++; $display("FAIL drain_discard: got %b want 000", {wb_valid, bus_err, stall_req}); end
    mem_txn(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 5'd10, 0, 0, 1'b1, 32'h1357_9BDF);
    vectors++; if ({t_wv, t_wd, t_stalls} !== {1'b1, 32'h1357_9BDF, 32'd3}) begin miscompares++; $display("FAIL after_drain: got %b %h %0d want 1 13579bdf 3", t_wv, t_wd, t_stalls); end
    // Flush while still waiting for gnt: request withdrawn.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_result = 32'h0000_0108;
    @(posedge clk); #1; flush = 1'b1; ex_valid = 1'b0; ex_mem_rd = 1'b0;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    vectors++; if ({ram_req, stall_req, wb_valid} !== 3'b000) begin miscompares++; $display("FAIL flush_req: got %b want 000", {ram_req, stall_req, wb_valid}); end
    // Flush beats ex_valid in IDLE.
    @(posedge clk); #1; flush = 1'b1; ex_valid = 1'b1; ex_result = 32'h0000_9999;
    @(negedge clk);
    vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL flush_idle_stall: got %b want 0", stall_req); end
    @(posedge clk); #1; flush = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    vectors++; if ({wb_valid, ram_req} !== 2'b00) begin miscompares++; $display("FAIL flush_idle_wb: got %b want 00", {wb_valid, ram_req}); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_mem_size = 2'b10; ex_result = 32'h0000_0600; ex_wdata = 32'h5555_AAAA;
    @(posedge clk); #1; rst = 1'b0; ex_valid = 1'b0; ex_mem_wr = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    vectors++; if ({ram_req, stall_req, ram_addr, ram_wdata} !== {2'b00, 64'h0}) begin miscompares++; $display("FAIL reset_mid: got %b %b %h %h want 0 0 0 0", ram_req, stall_req, ram_addr, ram_wdata); end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_size = 2'b10; ex_result = 32'h0000_0102; ex_reg_addr = 5'd11; ex_reg_en = 1'b1;
    @(negedge clk);
    vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL misalign_stall: got %b want 0", stall_req); end
    @(posedge clk); #1; ex_valid = 1'b0; ex_mem_rd = 1'b0;
    @(negedge clk);
    vectors++; if ({ram_req, wb_valid, wb_reg_en, exc_misalign} !== 4'b0101) begin miscompares++; $display("FAIL misalign_ctrl: got %b want 0101", {ram_req, wb_valid, wb_reg_en, exc_misalign}); end
    vectors++; if (exc_badaddr !== 32'h0000_0102) begin miscompares++; $display("FAIL misalign_badaddr: got %h want 00000102", exc_badaddr); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if ({exc_misalign, ram_req} !== 2'b00) begin miscompares++; $display("FAIL misalign_pulse: got %b want 00", {exc_misalign, ram_req}); end
`else
    mem_txn(1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 5'd11, 0, 0, 1'b1, 32'h89AB_CDEF);
    vectors++; if ({t_addr, t_be, t_wd} !== {32'h0000_0100, 4'b1111, 32'h89AB_CDEF}) begin miscompares++; $display("FAIL lw_low_bits_ignored: got %h %b %h want 00000100 1111 89abcdef", t_addr, t_be, t_wd); end
    mem_txn(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 5'd11, 0, 0, 1'b1, 32'h1234_5678);
    vectors++; if ({t_be, t_wd} !== {4'b0011, 32'h0000_5678}) begin miscompares++; $display("FAIL lh_addr0_ignored: got %b %h want 0011 00005678", t_be, t_wd); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthrough();
    test_load_word();
    test_load_subword();
    test_store();
    test_gnt_stall();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
